// File: rtl/sd_pkg.sv
// Shared SD definitions: CRC7 polynomial, response lengths, NCR timeout, receiver states.
// Latency: n/a (constants only). Backpressure: n/a.
package sd_pkg;

    localparam logic [6:0] CRC7_POLY   = 7'h09;  // x^7 + x^3 + 1
    localparam int         RESP_SHORT  = 48;
    localparam int         RESP_LONG   = 136;
    localparam int         NCR_TIMEOUT = 64;

    typedef enum logic [1:0] {
        RX_IDLE       = 2'd0,
        RX_WAIT_START = 2'd1,
        RX_RECEIVE    = 2'd2,
        RX_DONE       = 2'd3
    } rx_state_e;

    localparam logic [1:0] ST_IDLE       = RX_IDLE;
    localparam logic [1:0] ST_WAIT_START = RX_WAIT_START;
    localparam logic [1:0] ST_RECEIVE    = RX_RECEIVE;
    localparam logic [1:0] ST_DONE       = RX_DONE;

endpackage

// File: rtl/sd_resp_rx_if.sv
// Control/result bundle between the SD controller FSM (master) and the response receiver (slave).
// Latency: n/a (wires only). Backpressure: none, istrobe paces the receiver.
interface sd_resp_rx_if;
    logic         istrobe;
    logic         icmd;
    logic         istart;
    logic         ilong;
    logic         inocrc;
    logic         obusy;
    logic         odone;
    logic [5:0]   oindex;
    logic [127:0] oresp;
    logic         ocrc_err;
    logic         oframe_err;
    logic         otimeout;

    modport slave (
        input  istrobe, icmd, istart, ilong, inocrc,
        output obusy, odone, oindex, oresp, ocrc_err, oframe_err, otimeout
    );

    modport master (
        output istrobe, icmd, istart, ilong, inocrc,
        input  obusy, odone, oindex, oresp, ocrc_err, oframe_err, otimeout
    );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), zero seed; shared by the command transmitter and response receiver.
// Latency: 1 cycle per enabled bit. Backpressure: none, en gates each bit.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q, crc_d;
    logic       fb;

    always_comb begin
        fb    = din ^ crc_q[6];
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= '0;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: 48/136-bit frames with CRC7, framing and NCR timeout checks.
// Latency: odone 2 iclk after the end-bit (or timeout) strobe. Backpressure: none, istrobe paces input.
module sd_resp_rx
    import sd_pkg::*;
#(
    parameter int TIMEOUT = NCR_TIMEOUT
) (
    input  logic        iclk,
    input  logic        irst,
    sd_resp_rx_if.slave rx
);

    logic [1:0]   state_q, state_d;
    logic         long_q, long_d;
    logic         nocrc_q, nocrc_d;
    logic [15:0]  strobe_cnt_q, strobe_cnt_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   bit_cnt_next;
    logic [135:0] sreg_q, sreg_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [5:0]   index_q, index_d;
    logic [127:0] resp_q, resp_d;
    logic         crc_err_q, crc_err_d;
    logic         frame_err_q, frame_err_d;
    logic         timeout_q, timeout_d;

    logic         crc_clr, crc_en;
    logic [6:0]   crc_val;
    logic         unused_start_bit;

    // The start bit lands in sreg[135] of a long frame and is never read back.
    assign unused_start_bit = sreg_q[135];

    sd_crc7 u_crc7 (
        .clk (iclk),
        .rst (irst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (rx.icmd),
        .crc (crc_val)
    );

    always_comb begin
        state_d      = state_q;
        long_d       = long_q;
        nocrc_d      = nocrc_q;
        strobe_cnt_d = strobe_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        bit_cnt_next = bit_cnt_q + 8'd1;
        sreg_d       = sreg_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        index_d      = index_q;
        resp_d       = resp_q;
        crc_err_d    = crc_err_q;
        frame_err_d  = frame_err_q;
        timeout_d    = timeout_q;
        crc_clr      = 1'b0;
        crc_en       = 1'b0;

        if (done_q) busy_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx.istart) begin
                    long_d       = rx.ilong;
                    nocrc_d      = rx.inocrc;
                    strobe_cnt_d = '0;
                    crc_err_d    = 1'b0;
                    frame_err_d  = 1'b0;
                    timeout_d    = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (rx.istrobe) begin
                    if (!rx.icmd) begin
                        // A zero start bit leaves a zero-seeded CRC unchanged, so clearing covers it.
                        crc_clr   = 1'b1;
                        bit_cnt_d = 8'd1;
                        sreg_d    = {sreg_q[134:0], 1'b0};
                        state_d   = ST_RECEIVE;
                    end else begin
                        strobe_cnt_d = strobe_cnt_q + 16'd1;
                        if (strobe_cnt_q + 16'd1 == 16'(TIMEOUT)) begin
                            timeout_d = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end
                end
            end
            ST_RECEIVE: begin
                if (rx.istrobe) begin
                    sreg_d    = {sreg_q[134:0], rx.icmd};
                    bit_cnt_d = bit_cnt_next;
                    if (bit_cnt_next == 8'd2 && rx.icmd) frame_err_d = 1'b1;
                    // Long frames cover bits 127..8 only; short frames cover 47..8.
                    if (long_q) crc_en = (bit_cnt_next >= 8'd9) && (bit_cnt_next <= 8'd128);
                    else        crc_en = (bit_cnt_next >= 8'd2) && (bit_cnt_next <= 8'd40);
                    if (bit_cnt_next == (long_q ? 8'(RESP_LONG) : 8'(RESP_SHORT)))
                        state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (!timeout_q) begin
                    if (!sreg_q[0]) frame_err_d = 1'b1;
                    if (!nocrc_q && (crc_val != sreg_q[7:1])) crc_err_d = 1'b1;
                    if (long_q) begin
                        index_d = sreg_q[133:128];
                        resp_d  = {sreg_q[127:1], 1'b0};
                    end else begin
                        index_d = sreg_q[45:40];
                        resp_d  = {96'd0, sreg_q[39:8]};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q      <= ST_IDLE;
            long_q       <= 1'b0;
            nocrc_q      <= 1'b0;
            strobe_cnt_q <= '0;
            bit_cnt_q    <= '0;
            sreg_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            index_q      <= '0;
            resp_q       <= '0;
            crc_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            long_q       <= long_d;
            nocrc_q      <= nocrc_d;
            strobe_cnt_q <= strobe_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sreg_q       <= sreg_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            index_q      <= index_d;
            resp_q       <= resp_d;
            crc_err_q    <= crc_err_d;
            frame_err_q  <= frame_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign rx.obusy      = busy_q;
    assign rx.odone      = done_q;
    assign rx.oindex     = index_q;
    assign rx.oresp      = resp_q;
    assign rx.ocrc_err   = crc_err_q;
    assign rx.oframe_err = frame_err_q;
    assign rx.otimeout   = timeout_q;

endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed bench for sd_resp_rx: short/long/R3 frames, CRC and framing errors, NCR boundary, reset.
module tb_sd_resp_rx;
    import sd_pkg::*;

    logic iclk = 1'b0;
    logic irst = 1'b1;
    always #5 iclk = ~iclk;

    sd_resp_rx_if bus();

    sd_resp_rx #(.TIMEOUT(NCR_TIMEOUT)) dut (
        .iclk (iclk),
        .irst (irst),
        .rx   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent bit-serial CRC7 over the nbits LSBs of d, MSB first.
    function automatic logic [6:0] crc7(input logic [135:0] d, input int nbits);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = nbits - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'b0001001;
        end
        return c;
    endfunction

    function automatic logic [135:0] short_frame(input logic tbit, input logic [5:0] idx,
                                                 input logic [31:0] arg, input logic [6:0] crc);
        return {88'd0, 1'b0, tbit, idx, arg, crc, 1'b1};
    endfunction

    function automatic logic [6:0] short_crc(input logic tbit, input logic [5:0] idx,
                                             input logic [31:0] arg);
        logic [135:0] d;
        d = {96'd0, 1'b0, tbit, idx, arg};
        return crc7(d, 40);
    endfunction

    // Called at a falling edge; leaves istart low at the next falling edge.
    task automatic arm(input logic lng, input logic nc);
        bus.istart = 1'b1;
        bus.ilong  = lng;
        bus.inocrc = nc;
        @(negedge iclk);
        bus.istart = 1'b0;
        bus.ilong  = ~lng;
        bus.inocrc = ~nc;
    endtask

    task automatic send_bit(input logic b, input int gap);
        for (int i = 1; i < gap; i++) begin
            bus.istrobe = 1'b0;
            bus.icmd    = 1'($urandom);
            @(negedge iclk);
        end
        bus.istrobe = 1'b1;
        bus.icmd    = b;
        @(negedge iclk);
    endtask

    task automatic send_frame(input logic [135:0] f, input int len, input int idle, input int gap);
        for (int i = 0; i < idle; i++) send_bit(1'b1, gap);
        for (int i = len - 1; i >= 0; i--) send_bit(f[i], gap);
    endtask

    // Checks the 2-cycle odone latency after the last strobe and obusy falling right after.
    task automatic finish(input string tag);
        bus.istrobe = 1'b0;
        bus.icmd    = 1'b1;
        check({tag, " odone_early"}, 128'(bus.odone), 128'd0);
        @(negedge iclk);
        check({tag, " odone"}, 128'(bus.odone), 128'd1);
        check({tag, " obusy_with_done"}, 128'(bus.obusy), 128'd1);
        @(negedge iclk);
        check({tag, " odone_pulse"}, 128'(bus.odone), 128'd0);
        check({tag, " obusy_fall"}, 128'(bus.obusy), 128'd0);
    endtask

    task automatic check_out(input string tag, input logic [5:0] idx, input logic [127:0] resp,
                             input logic ce, input logic fe, input logic to);
        check({tag, " oindex"}, 128'(bus.oindex), 128'(idx));
        check({tag, " oresp"}, bus.oresp, resp);
        check({tag, " ocrc_err"}, 128'(bus.ocrc_err), 128'(ce));
        check({tag, " oframe_err"}, 128'(bus.oframe_err), 128'(fe));
        check({tag, " otimeout"}, 128'(bus.otimeout), 128'(to));
    endtask

    logic [6:0]   c_r1, c_bad, c_tb, c_r2, c_post;
    logic [119:0] cid;
    logic [135:0] frame;

    initial begin
        bus.istrobe = 1'b0;
        bus.icmd    = 1'b1;
        bus.istart  = 1'b0;
        bus.ilong   = 1'b0;
        bus.inocrc  = 1'b0;
        cid    = 120'h0353_4453_4431_3647_8012_3456_7801_AB;
        c_r1   = short_crc(1'b0, 6'd55, 32'h0000_0120);
        c_tb   = short_crc(1'b1, 6'd55, 32'h0000_0120);
        c_post = short_crc(1'b0, 6'd17, 32'hDEAD_BEEF);
        c_r2   = crc7({16'd0, cid}, 120);

        repeat (3) @(negedge iclk);
        check("reset obusy", 128'(bus.obusy), 128'd0);
        check("reset odone", 128'(bus.odone), 128'd0);
        check_out("reset", 6'd0, 128'd0, 1'b0, 1'b0, 1'b0);
        irst = 1'b0;
        @(negedge iclk);

        // Short R1, strobe spacing 2
        arm(1'b0, 1'b0);
        check("r1 obusy_armed", 128'(bus.obusy), 128'd1);
        send_frame(short_frame(1'b0, 6'd55, 32'h0000_0120, c_r1), 48, 5, 2);
        finish("r1");
        check_out("r1", 6'd55, 128'h120, 1'b0, 1'b0, 1'b0);

        // CRC error, armed in the cycle after odone, strobe spacing 180
        arm(1'b0, 1'b0);
        send_frame(short_frame(1'b0, 6'd55, 32'h0000_0121, c_r1), 48, 5, 180);
        finish("crcerr");
        check_out("crcerr", 6'd55, 128'h121, 1'b1, 1'b0, 1'b0);

        // Transmission bit 1 with a CRC that matches it
        arm(1'b0, 1'b0);
        send_frame(short_frame(1'b1, 6'd55, 32'h0000_0120, c_tb), 48, 2, 2);
        finish("tbit");
        check_out("tbit", 6'd55, 128'h120, 1'b0, 1'b1, 1'b0);

        // R3: reserved CRC field of all ones, CRC check skipped
        arm(1'b0, 1'b1);
        send_frame(short_frame(1'b0, 6'h3F, 32'h80FF_8000, 7'h7F), 48, 3, 2);
        finish("r3");
        check_out("r3", 6'd63, 128'h80FF_8000, 1'b0, 1'b0, 1'b0);

        // Long R2 carrying a CID
        arm(1'b1, 1'b0);
        frame = {2'b00, 6'h3F, cid, c_r2, 1'b1};
        send_frame(frame, 136, 4, 2);
        finish("r2");
        check_out("r2", 6'd63, {cid, c_r2, 1'b0}, 1'b0, 1'b0, 1'b0);

        // Start bit on the very last allowed strobe
        arm(1'b0, 1'b0);
        send_frame(short_frame(1'b0, 6'd55, 32'h0000_0120, c_r1), 48, NCR_TIMEOUT - 1, 2);
        finish("ncr_edge");
        check_out("ncr_edge", 6'd55, 128'h120, 1'b0, 1'b0, 1'b0);

        // No start bit: timeout on strobe 64, previous results held
        arm(1'b0, 1'b0);
        for (int i = 0; i < NCR_TIMEOUT - 1; i++) send_bit(1'b1, 2);
        check("timeout busy_before", 128'(bus.obusy), 128'd1);
        check("timeout flag_before", 128'(bus.otimeout), 128'd0);
        send_bit(1'b1, 2);
        finish("timeout");
        check_out("timeout", 6'd55, 128'h120, 1'b0, 1'b0, 1'b1);

        // Reset during bit 20 of a frame
        arm(1'b0, 1'b0);
        frame = short_frame(1'b0, 6'd17, 32'hDEAD_BEEF, c_post);
        for (int i = 47; i > 27; i--) send_bit(frame[i], 2);
        bus.istrobe = 1'b0;
        irst = 1'b1;
        @(negedge iclk);
        check("rst_mid obusy", 128'(bus.obusy), 128'd0);
        check("rst_mid odone", 128'(bus.odone), 128'd0);
        check_out("rst_mid", 6'd0, 128'd0, 1'b0, 1'b0, 1'b0);
        irst = 1'b0;
        @(negedge iclk);
        arm(1'b0, 1'b0);
        send_frame(frame, 48, 1, 2);
        finish("post_rst");
        check_out("post_rst", 6'd17, 128'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
